// File: rtl/shift_seq_ctrl_if.sv
// rtl/shift_seq_ctrl_if.sv - front-panel inputs and datapath strobes of the shift sequencer
//
// Purpose: groups the raw panel inputs and the shift/clear strobes so the
// sequencer and whatever drives/consumes it connect through one bundle.
// Signals:
//   key_n, clr_n  raw active-low buttons (asynchronous)
//   auto_mode     raw level switch, 1 = timer-driven shifting
//   sw_in         raw serial data bit
//   shift_en      one-cycle shift strobe, shift_bit valid with it
//   clr           one-cycle clear strobe
//   state         sequencer state code, busy = state not IDLE
//   shift_cnt     shifts issued since last clear/reset
// Modports: master drives the raw inputs, slave is the sequencer.
interface shift_seq_ctrl_if;
  logic       key_n;
  logic       clr_n;
  logic       auto_mode;
  logic       sw_in;
  logic       shift_en;
  logic       shift_bit;
  logic       clr;
  logic [1:0] state;
  logic       busy;
  logic [7:0] shift_cnt;

  modport master (
    output key_n, clr_n, auto_mode, sw_in,
    input  shift_en, shift_bit, clr, state, busy, shift_cnt
  );

  modport slave (
    input  key_n, clr_n, auto_mode, sw_in,
    output shift_en, shift_bit, clr, state, busy, shift_cnt
  );
endinterface

// File: rtl/shift_seq_ctrl.sv
// rtl/shift_seq_ctrl.sv - debounced button / auto-timer shift sequencer
//
// Purpose: synchronizes and debounces the panel buttons, turns button presses
// and auto-timer expiries into single-cycle shift or clear strobes for a
// downstream shift register, and counts the shifts issued.
// Ports:
//   CLOCK_50  single clock, all state on the rising edge
//   RESET     synchronous active-high reset
//   bus       shift_seq_ctrl_if.slave (raw inputs in, strobes/status out)
// shift_cnt is updated on entry to SHIFT/CLEAR, so it already shows the new
// value during the strobe cycle.
module shift_seq_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int AUTO_DIV        = 8
) (
  input  logic             CLOCK_50,
  input  logic             RESET,
  shift_seq_ctrl_if.slave  bus
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int TW = $clog2(AUTO_DIV);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] TMR_LAST = TW'(AUTO_DIV - 1);

  // Synchronizer bit order {sw_in, auto_mode, clr_n, key_n}; buttons idle high.
  localparam logic [3:0] SYNC_RST = 4'b0011;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    HOLD  = 2'b10,
    CLEAR = 2'b11
  } state_t;

  logic [3:0]    sync1, sync2;
  logic [1:0]    sync_vld;
  logic [DW-1:0] deb_cnt [2];
  logic [1:0]    deb, deb_d1, armed, press;   // index 0 = key, 1 = clr
  logic [TW-1:0] timer_q;
  state_t        state_q, state_d;
  logic          manual_q, manual_d;
  logic          load_bit;
  logic          timer_expire;
  logic          shift_bit_q;
  logic [7:0]    shift_cnt_q;

  logic auto_s;
  logic sw_s;
  assign auto_s = sync2[2];
  assign sw_s   = sync2[3];

  // Input conditioning. sync_vld marks when sync2 carries post-reset samples
  // rather than its reset value. A button is only armed once it has been seen
  // released, so a button held through reset never yields a press.
  // Press strobes are registered once more after the debounced fall.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      sync1    <= SYNC_RST;
      sync2    <= SYNC_RST;
      sync_vld <= 2'd0;
      deb      <= 2'b11;
      deb_d1   <= 2'b11;
      armed    <= 2'b00;
      press    <= 2'b00;
      for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
    end else begin
      sync1  <= {bus.sw_in, bus.auto_mode, bus.clr_n, bus.key_n};
      sync2  <= sync1;
      deb_d1 <= deb;
      if (sync_vld != 2'd2) sync_vld <= sync_vld + 2'd1;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          deb[i]     <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DW'(1);
        end
        if (sync_vld == 2'd2 && sync2[i] && deb[i]) armed[i] <= 1'b1;
        press[i] <= armed[i] & deb_d1[i] & ~deb[i];
      end
    end
  end

  // Next-state logic. Clear beats manual key beats auto timer; losers are dropped.
  always_comb begin
    state_d      = state_q;
    manual_d     = manual_q;
    load_bit     = 1'b0;
    timer_expire = (state_q == IDLE) && auto_s && (timer_q == TMR_LAST);
    case (state_q)
      IDLE: begin
        if (press[1]) begin
          state_d = CLEAR;
        end else if (press[0]) begin
          state_d  = SHIFT;
          manual_d = 1'b1;
          load_bit = 1'b1;
        end else if (timer_expire) begin
          state_d  = SHIFT;
          manual_d = 1'b0;
          load_bit = 1'b1;
        end
      end
      SHIFT:   state_d = manual_q ? HOLD : IDLE;
      CLEAR:   state_d = (deb == 2'b11) ? IDLE : HOLD;
      HOLD: begin
        if (press[1])           state_d = CLEAR;
        else if (deb == 2'b11)  state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state_q     <= IDLE;
      manual_q    <= 1'b0;
      shift_bit_q <= 1'b0;
      shift_cnt_q <= 8'd0;
      timer_q     <= '0;
    end else begin
      state_q  <= state_d;
      manual_q <= manual_d;
      if (load_bit) shift_bit_q <= sw_s;
      if (state_d == SHIFT)      shift_cnt_q <= shift_cnt_q + 8'd1;
      else if (state_d == CLEAR) shift_cnt_q <= 8'd0;
      // Timer runs only while idling in auto mode; leaving IDLE zeroes it.
      if (state_q == IDLE && auto_s)
        timer_q <= (timer_q == TMR_LAST) ? '0 : timer_q + TW'(1);
      else
        timer_q <= '0;
    end
  end

  assign bus.state     = state_q;
  assign bus.shift_en  = (state_q == SHIFT);
  assign bus.clr       = (state_q == CLEAR);
  assign bus.busy      = (state_q != IDLE);
  assign bus.shift_bit = shift_bit_q;
  assign bus.shift_cnt = shift_cnt_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb/tb_shift_seq_ctrl.sv - self-checking bench for shift_seq_ctrl
module tb_shift_seq_ctrl;
  localparam int DEB  = 4;
  localparam int ADIV = 8;

  logic CLOCK_50 = 1'b0;
  logic RESET;
  always #5 CLOCK_50 = ~CLOCK_50;

  shift_seq_ctrl_if bus ();

  shift_seq_ctrl #(.DEBOUNCE_CYCLES(DEB), .AUTO_DIV(ADIV)) dut (
    .CLOCK_50 (CLOCK_50),
    .RESET    (RESET),
    .bus      (bus)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: each signal is sampled two edges late, a debounced level
  // flips after DEB consecutive disagreeing samples, and the sequencer reacts
  // to a press two edges after the debounced fall.
  logic [3:0] dq[$];
  int         m_t;
  bit         m_valid = 1'b0;
  bit   [1:0] m_deb, m_armed;
  int         m_run [2];
  int         m_press_at [2];
  int         m_state, m_timer, m_cnt;
  bit         m_bit, m_manual;

  always @(posedge CLOCK_50) begin
    logic [3:0] raw, s;
    bit         vld, pk, pc, expire;
    bit   [1:0] deb_pre;
    int         nxt;
    raw = {bus.sw_in, bus.auto_mode, bus.clr_n, bus.key_n};
    if (RESET) begin
      m_t = 0; dq.delete();
      m_deb = 2'b11; m_armed = 2'b00;
      m_run[0] = 0; m_run[1] = 0; m_press_at[0] = -1; m_press_at[1] = -1;
      m_state = 0; m_timer = 0; m_cnt = 0; m_bit = 0; m_manual = 0;
      m_valid = 1'b1;
    end else begin
      m_t++;
      vld = (dq.size() == 2);
      s   = vld ? dq[0] : 4'b0011;
      dq.push_back(raw);
      if (dq.size() > 2) dq.pop_front();
      pk = (m_press_at[0] == m_t);
      pc = (m_press_at[1] == m_t);
      deb_pre = m_deb;
      expire = (m_state == 0) && s[2] && (m_timer == ADIV - 1);
      nxt = m_state;
      case (m_state)
        0: begin
          if (pc) nxt = 3;
          else if (pk)     begin nxt = 1; m_manual = 1; m_bit = s[3]; end
          else if (expire) begin nxt = 1; m_manual = 0; m_bit = s[3]; end
        end
        1: nxt = m_manual ? 2 : 0;
        2: begin
          if (pc) nxt = 3;
          else if (deb_pre == 2'b11) nxt = 0;
        end
        default: nxt = (deb_pre == 2'b11) ? 0 : 2;
      endcase
      if (m_state == 0 && s[2]) m_timer = (m_timer + 1) % ADIV;
      else m_timer = 0;
      if (nxt == 1) m_cnt = (m_cnt + 1) % 256;
      else if (nxt == 3) m_cnt = 0;
      m_state = nxt;
      for (int i = 0; i < 2; i++) begin
        if (s[i] != m_deb[i]) begin
          m_run[i]++;
          if (m_run[i] == DEB) begin
            if (m_armed[i] && !s[i]) m_press_at[i] = m_t + 2;
            m_deb[i] = s[i];
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
          if (vld && s[i]) m_armed[i] = 1'b1;
        end
      end
    end
  end

  typedef struct {
    int key_len;
    int clr_len;
    bit sw;
    int exp_shifts;
    int exp_clrs;
    int exp_cnt;
    bit exp_bit;
  } vec_t;

  vec_t tbl [8];

  int n_shift = 0, n_clr = 0, n_busy = 0, cyc_no = 0;
  bit last_bit;
  int pulse_cyc[$];

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    bus.key_n = 1'b1; bus.clr_n = 1'b1; bus.auto_mode = 1'b0; bus.sw_in = 1'b0;
    cyc(2);
    RESET = 1'b0;
    cyc(6);
  endtask

  task automatic wait_state(input logic [1:0] st, input int bound, input string nm);
    int k;
    k = 0;
    while (bus.state !== st && k < bound) begin
      cyc(1);
      k++;
    end
    check(nm, longint'(bus.state), longint'(st));
  endtask

  initial begin
    int base, pbase, cycles_done;
    longint exp_pack;
    RESET = 1'b1;
    bus.key_n = 1'b1; bus.clr_n = 1'b1; bus.auto_mode = 1'b0; bus.sw_in = 1'b0;

    fork
      forever begin
        @(negedge CLOCK_50);
        if (m_valid) begin
          exp_pack = {m_state[1:0], m_state == 1, m_state == 3, m_state != 0, m_bit, m_cnt[7:0]};
          check("model", longint'({bus.state, bus.shift_en, bus.clr, bus.busy, bus.shift_bit, bus.shift_cnt}), exp_pack);
        end
      end
      forever begin
        @(posedge CLOCK_50);
        cyc_no++;
        #2;
        if (bus.shift_en) begin n_shift++; last_bit = bus.shift_bit; pulse_cyc.push_back(cyc_no); end
        if (bus.clr)  n_clr++;
        if (bus.busy) n_busy++;
      end
    join_none

    tbl[0] = '{20,  0, 1'b1, 1, 0, 1, 1'b1};
    tbl[1] = '{20,  0, 1'b0, 1, 0, 2, 1'b0};
    tbl[2] = '{ 3,  0, 1'b1, 0, 0, 2, 1'b0};
    tbl[3] = '{ 4,  0, 1'b1, 1, 0, 3, 1'b1};
    tbl[4] = '{ 0, 10, 1'b0, 0, 1, 0, 1'b0};
    tbl[5] = '{20,  0, 1'b1, 1, 0, 1, 1'b1};
    tbl[6] = '{10, 10, 1'b1, 0, 1, 0, 1'b0};
    tbl[7] = '{ 0,  2, 1'b0, 0, 0, 0, 1'b0};

    // Reset values
    do_reset();
    check("reset_outputs", longint'({bus.state, bus.shift_en, bus.clr, bus.busy, bus.shift_bit, bus.shift_cnt}), 0);

    // Table: press patterns applied back to back, counts accumulate
    for (int r = 0; r < 8; r++) begin
      int s0, c0;
      s0 = n_shift; c0 = n_clr;
      bus.sw_in = tbl[r].sw;
      for (int c = 0; c < 40; c++) begin
        bus.key_n = (c < tbl[r].key_len) ? 1'b0 : 1'b1;
        bus.clr_n = (c < tbl[r].clr_len) ? 1'b0 : 1'b1;
        cyc(1);
      end
      cyc(20);
      check($sformatf("tbl%0d_shifts", r), n_shift - s0, tbl[r].exp_shifts);
      check($sformatf("tbl%0d_clrs", r), n_clr - c0, tbl[r].exp_clrs);
      check($sformatf("tbl%0d_cnt", r), bus.shift_cnt, tbl[r].exp_cnt);
      check($sformatf("tbl%0d_state", r), bus.state, 0);
      if (tbl[r].exp_shifts > 0) check($sformatf("tbl%0d_bit", r), last_bit, tbl[r].exp_bit);
    end

    // Manual press latency and HOLD
    do_reset();
    base = n_shift;
    bus.sw_in = 1'b1; bus.key_n = 1'b0;
    for (int e = 0; e <= 7; e++) begin
      @(posedge CLOCK_50); #1;
      if (e == 6) check("latency_early", bus.shift_en, 0);
    end
    check("latency_hit", bus.shift_en, 1);
    check("manual_bit", bus.shift_bit, 1);
    check("manual_cnt", bus.shift_cnt, 1);
    cyc(12);
    check("hold_while_pressed", bus.state, 2);
    bus.key_n = 1'b1;
    wait_state(2'd0, 20, "hold_to_idle");
    check("manual_single_pulse", n_shift - base, 1);

    // Bounce never produces a shift
    do_reset();
    base = n_shift;
    pbase = n_busy;
    for (int i = 0; i < 12; i++) begin
      bus.key_n = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
      cyc(1);
    end
    bus.key_n = 1'b1;
    cyc(20);
    check("bounce_shifts", n_shift - base, 0);
    check("bounce_busy", n_busy - pbase, 0);

    // Auto mode period
    do_reset();
    base = n_shift;
    pbase = pulse_cyc.size();
    bus.auto_mode = 1'b1;
    cyc(40);
    bus.auto_mode = 1'b0;
    check("auto_pulses", n_shift - base, 4);
    check("auto_cnt", bus.shift_cnt, 4);
    for (int k = pbase + 1; k < pulse_cyc.size(); k++)
      check($sformatf("auto_period%0d", k - pbase), pulse_cyc[k] - pulse_cyc[k-1], 9);
    base = n_shift;
    cyc(30);
    check("auto_stopped", n_shift - base, 0);

    // Counter wrap after 256 auto shifts
    do_reset();
    base = n_shift;
    bus.auto_mode = 1'b1;
    for (int k = 0; k < 3000 && (n_shift - base) < 255; k++) cyc(1);
    check("wrap_cnt255", bus.shift_cnt, 255);
    for (int k = 0; k < 20 && (n_shift - base) < 256; k++) cyc(1);
    check("wrap_cnt0", bus.shift_cnt, 0);
    bus.auto_mode = 1'b0;
    cyc(5);

    // Reset in HOLD with key still held
    do_reset();
    bus.key_n = 1'b0;
    wait_state(2'd2, 30, "reach_hold");
    RESET = 1'b1;
    cyc(1);
    check("reset_abort_state", bus.state, 0);
    check("reset_abort_strobes", {bus.shift_en, bus.clr}, 0);
    RESET = 1'b0;
    base = n_shift;
    cyc(30);
    check("held_through_reset", n_shift - base, 0);
    bus.key_n = 1'b1;
    cyc(15);
    bus.key_n = 1'b0;
    cyc(20);
    bus.key_n = 1'b1;
    cyc(15);
    check("repress_after_reset", n_shift - base, 1);

    // Randomized traffic against the model
    do_reset();
    cycles_done = 0;
    for (int seg = 0; seg < 1000 && cycles_done < 3000; seg++) begin
      int r, len, kind, gap;
      r = $urandom_range(0, 99);
      if (r < 4) begin
        RESET = 1'b1;
        len = $urandom_range(1, 2);
        cyc(len);
        RESET = 1'b0;
        cycles_done += len;
      end else begin
        if ($urandom_range(0, 6) == 0) bus.auto_mode = ~bus.auto_mode;
        kind = $urandom_range(0, 3);
        len  = $urandom_range(1, 25);
        for (int c = 0; c < len; c++) begin
          bus.sw_in = 1'($urandom_range(0, 1));
          bus.key_n = (kind == 1) ? 1'b0 : (kind == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
          bus.clr_n = (kind == 3 && c < len / 2) ? 1'b0 :
                      (kind == 2 && $urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
          cyc(1);
        end
        bus.key_n = 1'b1;
        bus.clr_n = 1'b1;
        gap = $urandom_range(0, 15);
        cyc(gap);
        cycles_done += len + gap;
      end
    end
    bus.auto_mode = 1'b0;
    cyc(30);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/shift_seq_ctrl.md
SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16, SHALL set the consecutive stable cycles required before a synchronized button level is accepted (range 2..2^20).
REQ-002 Parameter AUTO_DIV, default 8, SHALL set the cycle period between automatic shifts (range 2..2^24).
REQ-003 CLOCK_50  input  1  single clock; all state updates on rising edge.
REQ-004 RESET  input  1  synchronous, active-high reset.
REQ-005 key_n  input  1  raw active-low shift button, asynchronous to CLOCK_50.
REQ-006 clr_n  input  1  raw active-low clear button, asynchronous.
REQ-007 auto_mode  input  1  raw level switch; 1 = timer-driven shifting enabled.
REQ-008 sw_in  input  1  raw serial data bit to be shifted into the downstream register.
REQ-009 shift_en  output  1  single-cycle shift strobe to the datapath.
REQ-010 shift_bit  output  1  data bit valid when shift_en=1.
REQ-011 clr  output  1  single-cycle clear strobe to the datapath.
REQ-012 state  output  2  FSM code: IDLE=00, SHIFT=01, HOLD=10, CLEAR=11.
REQ-013 busy  output  1  1 whenever state != IDLE.
REQ-014 shift_cnt  output  8  number of shifts issued since last clear/reset.

Function
REQ-015 key_n, clr_n, auto_mode, sw_in SHALL each pass through a 2-flop synchronizer before any other use.
REQ-016 Each synchronized button SHALL have its own debounce counter: counter resets to 0 when the synchronized level equals the debounced level, else increments; at DEBOUNCE_CYCLES-1 the debounced level SHALL take the synchronized level and the counter SHALL clear.
REQ-017 A press event SHALL be a 1->0 transition of a debounced level, lasting exactly one cycle; a release is a 0->1 transition.
REQ-018 Total latency from first CLOCK_50 edge sampling a stable raw press to shift_en/clr high SHALL be exactly DEBOUNCE_CYCLES+3 cycles.
REQ-019 IDLE: clear press -> CLEAR; else key press -> SHIFT (manual); else auto timer expiry -> SHIFT (auto); else stay.
REQ-020 SHIFT SHALL last one cycle with shift_en=1 and shift_bit = synchronized sw_in registered on IDLE exit; then -> HOLD if manual, -> IDLE if auto.
REQ-021 CLEAR SHALL last one cycle with clr=1; then -> IDLE if debounced clr_n and key_n are both 1, else -> HOLD.
REQ-022 HOLD SHALL remain until debounced key_n and clr_n are both 1, then -> IDLE; a clear press in HOLD -> CLEAR.
REQ-023 Priority on simultaneous events: clear > manual key > auto timer; the losing events SHALL be discarded, not queued.
REQ-024 Auto timer SHALL count 0..AUTO_DIV-1 only in IDLE with synchronized auto_mode=1, expire at AUTO_DIV-1, and reset to 0 on any SHIFT, CLEAR, or auto_mode=0.
REQ-025 shift_cnt SHALL increment on each SHIFT cycle, wrap 255->0, and clear to 0 in the CLEAR cycle.
REQ-026 shift_en and clr SHALL never be high in the same cycle; each strobe SHALL be high for exactly one cycle per accepted event.

Reset
REQ-027 With RESET=1 at a clock edge: state=IDLE, shift_en=0, clr=0, shift_bit=0, busy=0, shift_cnt=0, timer=0, debounce counters=0, synchronizers and debounced levels=1 (key_n, clr_n) / 0 (auto_mode, sw_in).
REQ-028 RESET asserted mid-operation (any state) SHALL abort on the next edge with no strobe issued; a button held through reset release SHALL NOT produce a press until released and re-pressed.

Verification (DEBOUNCE_CYCLES=4, AUTO_DIV=8)
REQ-029 Manual: sw_in=1, key_n low for 20 cycles then high -> one shift_en pulse 7 cycles after press, shift_bit=1, shift_cnt=1, HOLD until release debounced, then IDLE.
REQ-030 Bounce: key_n toggles every 2 cycles for 12 cycles then stays high -> no shift_en, state stays IDLE.
REQ-031 Auto: auto_mode=1 for 40 cycles -> shift_en every 9 cycles (8 IDLE + 1 SHIFT), shift_cnt increments each pulse; auto_mode=0 -> pulses stop.
REQ-032 Simultaneous: key_n and clr_n fall same cycle -> clr pulse only, shift_cnt=0, no shift_en, then HOLD until both released.
REQ-033 Wrap: 256 auto shifts from reset -> shift_cnt reads 0 after the 256th.
REQ-034 Reset mid-HOLD with key_n still low -> IDLE next edge, no shift_en after RESET drops until key released and pressed again.
